// File: rtl/uart_pkg.sv
// Shared types and sizes for the UART frame controller.
package uart_pkg;

    localparam int BUF_DEPTH = 8;
    localparam int ADDR_W    = 4;
    localparam int TMO_W     = 30;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_LEN   = 3'd2,
        ST_DATA  = 3'd3,
        ST_CHK   = 3'd4,
        ST_WRITE = 3'd5
    } state_t;

    // A frame may carry 1..BUF_DEPTH data bytes.
    function automatic logic len_valid(input logic [7:0] len);
        return (len != 8'd0) && (len <= 8'(BUF_DEPTH));
    endfunction

endpackage

// File: rtl/uart_timeout_cnt.sv
// Inter-byte gap counter: counts while enabled, saturates at LIMIT, flags expiry.
module uart_timeout_cnt
    import uart_pkg::*;
#(
    parameter logic [TMO_W-1:0] LIMIT = '1
)(
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TMO_W-1:0] cnt_q;
    logic [TMO_W-1:0] cnt_d;

    // Next count: clear has priority, then count up until the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = enable && (cnt_q == LIMIT);

endmodule

// File: rtl/uart_frame_ctrl.sv
// Frame parser: HEAD, ADDR, LEN, DATA[LEN], CHK -> burst of register writes.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  ST_IDLE  | hunting for HEAD, other bytes dropped
//  ST_ADDR  | waiting for start address byte
//  ST_LEN   | waiting for length byte (1..8 accepted)
//  ST_DATA  | collecting data bytes into the buffer
//  ST_CHK   | waiting for checksum byte (sum of ADDR, LEN, DATA mod 256)
//  ST_WRITE | one register write per cycle, LEN cycles, rx bytes ignored
module uart_frame_ctrl
    import uart_pkg::*;
#(
    parameter int         CLOCK_FERQ    = 50_000_000,
    parameter int         BAUD          = 9600,
    parameter int         TIMEOUT_BYTES = 3,
    parameter logic [7:0] HEAD          = 8'h55
)(
    input  logic              i_sysclk,
    input  logic              i_sysrst,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_done,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [7:0]        o_wr_data,
    output logic              o_frame_ok,
    output logic              o_frame_err,
    output logic              o_busy
);

    // Gap limit in clocks: TIMEOUT_BYTES 10-bit byte times, counted from 0.
    localparam longint TMO_CYCLES = (longint'(TIMEOUT_BYTES) * 64'sd10 * longint'(CLOCK_FERQ))
                                    / longint'(BAUD);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TMO_CYCLES - 64'sd1);

    state_t                        state_q, state_d;
    logic [ADDR_W-1:0]             start_q, start_d;
    logic [3:0]                    len_q, len_d;
    logic [3:0]                    idx_q, idx_d;
    logic [7:0]                    sum_q, sum_d;
    logic [BUF_DEPTH-1:0][7:0]     buf_q, buf_d;
    logic                          ok_q, ok_d;
    logic                          err_q, err_d;
    logic                          counting;
    logic                          tmo_expired;
    logic                          wr_active;

    assign counting = (state_q == ST_ADDR) || (state_q == ST_LEN) ||
                      (state_q == ST_DATA) || (state_q == ST_CHK);

    uart_timeout_cnt #(
        .LIMIT (TMO_LIMIT)
    ) u_timeout (
        .clk     (i_sysclk),
        .rst     (i_sysrst),
        .clear   (i_rx_done || !counting),
        .enable  (counting),
        .expired (tmo_expired)
    );

    // Next-state and datapath updates; a byte arriving on expiry wins.
    always_comb begin
        state_d = state_q;
        start_d = start_q;
        len_d   = len_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        buf_d   = buf_q;
        ok_d    = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_rx_done && (i_rx_data == HEAD)) begin
                    sum_d   = '0;
                    idx_d   = '0;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (i_rx_done) begin
                    start_d = i_rx_data[ADDR_W-1:0];
                    sum_d   = i_rx_data;
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (i_rx_done) begin
                    sum_d = sum_q + i_rx_data;
                    if (len_valid(i_rx_data)) begin
                        len_d   = i_rx_data[3:0];
                        idx_d   = '0;
                        state_d = ST_DATA;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (i_rx_done) begin
                    buf_d[idx_q[2:0]] = i_rx_data;
                    sum_d = sum_q + i_rx_data;
                    if (idx_q == (len_q - 4'd1)) begin
                        idx_d   = '0;
                        state_d = ST_CHK;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            ST_CHK: begin
                if (i_rx_done) begin
                    idx_d = '0;
                    if (i_rx_data == sum_q) begin
                        state_d = ST_WRITE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_WRITE: begin
                if (idx_q == (len_q - 4'd1)) begin
                    idx_d   = '0;
                    ok_d    = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (tmo_expired && !i_rx_done) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
        end
    end

    // State and datapath registers; reset aborts any frame in flight.
    always_ff @(posedge i_sysclk) begin
        if (i_sysrst) begin
            state_q <= ST_IDLE;
            start_q <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            sum_q   <= '0;
            buf_q   <= '0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            buf_q   <= buf_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
        end
    end

    assign wr_active   = (state_q == ST_WRITE);
    assign o_wr_en     = wr_active;
    assign o_wr_addr   = wr_active ? (start_q + idx_q) : '0;
    assign o_wr_data   = wr_active ? buf_q[idx_q[2:0]] : '0;
    assign o_frame_ok  = ok_q;
    assign o_frame_err = err_q;
    assign o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Self-checking bench for uart_frame_ctrl: directed frames plus randomized traffic.
module tb_uart_frame_ctrl;

    localparam int CLK_HZ    = 1_000_000;
    localparam int BAUD_R    = 100_000;
    localparam int TMO_BYTES = 3;
    localparam int LIMIT     = TMO_BYTES * 10 * CLK_HZ / BAUD_R - 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       frame_ok;
    logic       frame_err;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    logic [11:0] wr_log[$];
    int ok_seen  = 0;
    int err_seen = 0;

    always #5 clk = ~clk;

    uart_frame_ctrl #(
        .CLOCK_FERQ    (CLK_HZ),
        .BAUD          (BAUD_R),
        .TIMEOUT_BYTES (TMO_BYTES),
        .HEAD          (8'h55)
    ) dut (
        .i_sysclk    (clk),
        .i_sysrst    (rst),
        .i_rx_data   (rx_data),
        .i_rx_done   (rx_done),
        .o_wr_en     (wr_en),
        .o_wr_addr   (wr_addr),
        .o_wr_data   (wr_data),
        .o_frame_ok  (frame_ok),
        .o_frame_err (frame_err),
        .o_busy      (busy)
    );

    // Observe outputs mid-cycle: log writes, count pulses, check invariants.
    always @(negedge clk) begin
        if (wr_en === 1'b1) wr_log.push_back({wr_addr, wr_data});
        if (frame_ok === 1'b1) ok_seen++;
        if (frame_err === 1'b1) err_seen++;
        n_checks++;
        if ((frame_ok === 1'b1) && (frame_err === 1'b1)) begin
            n_errors++;
            $display("FAIL ok_err_same_cycle at %0t: ok=%b err=%b, required not both", $time, frame_ok, frame_err);
        end
        n_checks++;
        if ((wr_en === 1'b0) && ((wr_addr !== 4'h0) || (wr_data !== 8'h00))) begin
            n_errors++;
            $display("FAIL idle_bus_zero at %0t: addr=%h data=%h, required 0/00", $time, wr_addr, wr_data);
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        step();
        rx_done = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx_data = 8'h55;
        rx_done = 1'b1;
        idle(3);
        rx_done = 1'b0;
        rx_data = 8'h00;
        n_checks++;
        if ({wr_en, wr_addr, wr_data, frame_ok, frame_err, busy} !== 16'h0000) begin
            n_errors++;
            $display("FAIL reset_outputs: got en=%b addr=%h data=%h ok=%b err=%b busy=%b, required all 0",
                     wr_en, wr_addr, wr_data, frame_ok, frame_err, busy);
        end
        rst = 1'b0;
        idle(2);
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_idle_busy: got %b, required 0", busy);
        end
    endtask

    task automatic test_basic();
        send_byte(8'h55); send_byte(8'h03); send_byte(8'h02);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'h6A);
        n_checks++;
        if ({wr_en, wr_addr, wr_data} !== {1'b1, 4'h3, 8'hAA}) begin
            n_errors++;
            $display("FAIL basic_wr0: got en=%b addr=%h data=%h, required 1/3/AA", wr_en, wr_addr, wr_data);
        end
        step();
        n_checks++;
        if ({wr_en, wr_addr, wr_data} !== {1'b1, 4'h4, 8'hBB}) begin
            n_errors++;
            $display("FAIL basic_wr1: got en=%b addr=%h data=%h, required 1/4/BB", wr_en, wr_addr, wr_data);
        end
        step();
        n_checks++;
        if ({wr_en, frame_ok, frame_err} !== 3'b010) begin
            n_errors++;
            $display("FAIL basic_ok: got en=%b ok=%b err=%b, required 0/1/0", wr_en, frame_ok, frame_err);
        end
        step();
        n_checks++;
        if ({frame_ok, busy} !== 2'b00) begin
            n_errors++;
            $display("FAIL basic_after: got ok=%b busy=%b, required 0/0", frame_ok, busy);
        end
    endtask

    task automatic test_wrap();
        int b_ok;
        wr_log.delete();
        b_ok = ok_seen;
        send_byte(8'h55); send_byte(8'h0F); send_byte(8'h02);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h44);
        idle(6);
        n_checks++;
        if ((wr_log.size() != 2) || (wr_log[0] !== 12'hF11) || (wr_log[1] !== 12'h022)) begin
            n_errors++;
            $display("FAIL wrap_writes: got %0d writes first=%h, required 2 writes F11,022",
                     wr_log.size(), (wr_log.size() > 0) ? wr_log[0] : 12'h000);
        end
        n_checks++;
        if (ok_seen - b_ok != 1) begin
            n_errors++;
            $display("FAIL wrap_ok: got %0d ok pulses, required 1", ok_seen - b_ok);
        end
    endtask

    task automatic test_chk_err();
        int b_err;
        wr_log.delete();
        b_err = err_seen;
        send_byte(8'h55); send_byte(8'h01); send_byte(8'h01);
        send_byte(8'h10); send_byte(8'h00);
        n_checks++;
        if ({frame_err, busy, wr_en} !== 3'b100) begin
            n_errors++;
            $display("FAIL chk_err_pulse: got err=%b busy=%b en=%b, required 1/0/0", frame_err, busy, wr_en);
        end
        idle(10);
        n_checks++;
        if ((err_seen - b_err != 1) || (wr_log.size() != 0) || (busy !== 1'b0)) begin
            n_errors++;
            $display("FAIL chk_err_totals: got errs=%0d writes=%0d busy=%b, required 1/0/0",
                     err_seen - b_err, wr_log.size(), busy);
        end
    endtask

    task automatic test_len_err();
        int b_err;
        int b_ok;
        wr_log.delete();
        b_err = err_seen;
        b_ok  = ok_seen;
        send_byte(8'h55); send_byte(8'h01); send_byte(8'h09);
        n_checks++;
        if ({frame_err, busy} !== 2'b10) begin
            n_errors++;
            $display("FAIL len_err_pulse: got err=%b busy=%b, required 1/0", frame_err, busy);
        end
        send_byte(8'h00); send_byte(8'h12);
        send_byte(8'h55); send_byte(8'h02); send_byte(8'h01);
        send_byte(8'h7E); send_byte(8'h81);
        idle(5);
        n_checks++;
        if ((wr_log.size() != 1) || (wr_log[0] !== 12'h27E) || (ok_seen - b_ok != 1) || (err_seen - b_err != 1)) begin
            n_errors++;
            $display("FAIL len_err_resync: got writes=%0d ok=%0d errs=%0d, required 1 write 27E, 1 ok, 1 err",
                     wr_log.size(), ok_seen - b_ok, err_seen - b_err);
        end
    endtask

    task automatic test_timeout();
        int k;
        int b_err;
        int b_ok;
        send_byte(8'h55); send_byte(8'h01);
        k = 0;
        while ((frame_err !== 1'b1) && (k < LIMIT + 20)) begin
            step();
            k++;
        end
        n_checks++;
        if (k != LIMIT + 1) begin
            n_errors++;
            $display("FAIL timeout_latency: got err after %0d cycles, required %0d", k, LIMIT + 1);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL timeout_idle: got busy=%b, required 0", busy);
        end
        idle(3);
        wr_log.delete();
        b_err = err_seen;
        b_ok  = ok_seen;
        send_byte(8'h55); send_byte(8'h01);
        idle(LIMIT);
        send_byte(8'h02);
        send_byte(8'h33); send_byte(8'h44); send_byte(8'h7A);
        idle(5);
        n_checks++;
        if ((err_seen != b_err) || (ok_seen - b_ok != 1) || (wr_log.size() != 2) ||
            (wr_log[0] !== 12'h133) || (wr_log[1] !== 12'h244)) begin
            n_errors++;
            $display("FAIL timeout_byte_wins: got errs=%0d ok=%0d writes=%0d, required 0/1/2 (133,244)",
                     err_seen - b_err, ok_seen - b_ok, wr_log.size());
        end
    endtask

    task automatic test_reset_mid_write();
        int b_ok;
        wr_log.delete();
        b_ok = ok_seen;
        send_byte(8'h55); send_byte(8'h05); send_byte(8'h08);
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        send_byte(8'h31);
        n_checks++;
        if ({wr_en, wr_addr, wr_data} !== {1'b1, 4'h5, 8'h01}) begin
            n_errors++;
            $display("FAIL rst_wr0: got en=%b addr=%h data=%h, required 1/5/01", wr_en, wr_addr, wr_data);
        end
        step();
        rst = 1'b1;
        n_checks++;
        if ({wr_en, wr_addr, wr_data} !== {1'b1, 4'h6, 8'h02}) begin
            n_errors++;
            $display("FAIL rst_wr1: got en=%b addr=%h data=%h, required 1/6/02", wr_en, wr_addr, wr_data);
        end
        step();
        n_checks++;
        if ({wr_en, busy, frame_ok, frame_err} !== 4'b0000) begin
            n_errors++;
            $display("FAIL rst_abort: got en=%b busy=%b ok=%b err=%b, required 0", wr_en, busy, frame_ok, frame_err);
        end
        rst = 1'b0;
        idle(12);
        n_checks++;
        if ((ok_seen != b_ok) || (wr_log.size() != 2) || (busy !== 1'b0)) begin
            n_errors++;
            $display("FAIL rst_after: got ok=%0d writes=%0d busy=%b, required 0/2/0",
                     ok_seen - b_ok, wr_log.size(), busy);
        end
    endtask

    task automatic test_random();
        logic [11:0] exp_q[$];
        int exp_ok;
        int exp_err;
        int b_ok;
        int b_err;
        int njunk;
        int mode;
        logic [7:0] a;
        logic [7:0] l;
        logic [7:0] s;
        logic [7:0] b;
        logic [7:0] d;
        logic [3:0] ad;
        exp_ok  = 0;
        exp_err = 0;
        wr_log.delete();
        b_ok  = ok_seen;
        b_err = err_seen;
        for (int f = 0; f < 60; f++) begin
            njunk = $urandom_range(0, 2);
            for (int j = 0; j < njunk; j++) begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'h55) b = 8'h54;
                send_byte(b);
                idle($urandom_range(0, 3));
            end
            a    = 8'($urandom_range(0, 255));
            mode = $urandom_range(0, 7);
            if (mode == 0) l = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(9, 255));
            else           l = 8'($urandom_range(1, 8));
            send_byte(8'h55); idle($urandom_range(0, 5));
            send_byte(a);     idle($urandom_range(0, 5));
            send_byte(l);
            if (mode == 0) begin
                exp_err++;
            end else begin
                s = a + l;
                for (int i = 0; i < int'(l); i++) begin
                    idle($urandom_range(0, 5));
                    d = 8'($urandom_range(0, 255));
                    s = s + d;
                    ad = a[3:0] + 4'(i);
                    if (mode != 1) exp_q.push_back({ad, d});
                    send_byte(d);
                end
                idle($urandom_range(0, 5));
                if (mode == 1) begin
                    send_byte(s ^ 8'($urandom_range(1, 255)));
                    exp_err++;
                end else begin
                    send_byte(s);
                    exp_ok++;
                end
            end
            idle(12);
        end
        n_checks++;
        if ((ok_seen - b_ok != exp_ok) || (err_seen - b_err != exp_err)) begin
            n_errors++;
            $display("FAIL rand_counts: got ok=%0d err=%0d, required ok=%0d err=%0d",
                     ok_seen - b_ok, err_seen - b_err, exp_ok, exp_err);
        end
        n_checks++;
        if (wr_log.size() != exp_q.size()) begin
            n_errors++;
            $display("FAIL rand_write_count: got %0d, required %0d", wr_log.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (wr_log[i] !== exp_q[i]) begin
                    n_errors++;
                    $display("FAIL rand_write[%0d]: got %h, required %h", i, wr_log[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_chk_err();
        test_len_err();
        test_timeout();
        test_reset_mid_write();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
